// File: rtl/instr_loader.sv
// instr_loader: framed byte-stream loader writing 32-bit words into instruction RAM
module instr_loader #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;
  localparam logic [16:0] CAP = 17'(MEM_SIZE / 4);
  state_t state;
  logic [15:0] n, cnt, len;
  logic [1:0] idx;
  logic [23:0] word;
  logic [ADDR_W-1:0] addr;
  logic acc;
  assign acc = rx_valid & rx_ready;
  assign len = {n[15:8], rx_data};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      n <= '0;
      cnt <= '0;
      idx <= '0;
      word <= '0;
      addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      rx_ready <= 1'b0;
      wr_en <= 1'b0;
      cpu_hold <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state <= LEN_HI;
            addr <= '0;
            cnt <= '0;
            error <= 1'b0;
            rx_ready <= 1'b1;
            busy <= 1'b1;
            cpu_hold <= 1'b1;
          end else if (state == DONE) begin
            state <= IDLE;
            cpu_hold <= 1'b0;
          end
        end
        LEN_HI: if (acc) begin
          n[15:8] <= rx_data;
          state <= LEN_LO;
        end
        LEN_LO: if (acc) begin
          n[7:0] <= rx_data;
          idx <= '0;
          if (len == 16'd0 || {1'b0, len} > CAP) begin
            state <= (len == 16'd0) ? DONE : ERR;
            done <= (len == 16'd0);
            error <= (len != 16'd0);
            rx_ready <= 1'b0;
            busy <= 1'b0;
          end else
            state <= DATA;
        end
        DATA: if (acc) begin
          word <= {word[15:0], rx_data};
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= WRITE;
            rx_ready <= 1'b0;
            wr_en <= 1'b1;
            wr_data <= {word, rx_data};
            wr_addr <= addr;
          end
        end
        WRITE: begin
          addr <= addr + ADDR_W'(4);
          cnt <= cnt + 16'd1;
          if (cnt + 16'd1 == n) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= DATA;
            rx_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized scoreboard bench for instr_loader
module tb_instr_loader;
  logic clk = 0, reset_n = 0, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, wr_en, cpu_hold, busy, done, error;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  int checks = 0, failures = 0, done_seen = 0, exp_done = 0;
  logic [63:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] words[$];
  logic [63:0] last_addr = 0;
  bit alt = 0;

  instr_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    if (wr_en) begin
      chk("wr_hold", cpu_hold, 1);
      if (exp_a.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        chk("wr_addr", wr_addr, exp_a.pop_front());
        chk("wr_data", wr_data, exp_d.pop_front());
        last_addr = wr_addr;
      end
    end
    if (done) begin
      done_seen++;
      chk("done_hold", cpu_hold, 1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gaps);
    bit ok = 0;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk);
      alt = ~alt;
      if ((gaps == 1 && alt) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
        rx_valid = 0;
        rx_data = $urandom;
      end else begin
        rx_valid = 1;
        rx_data = b;
        ok = rx_ready;
        @(posedge clk);
      end
    end
    if (!ok) chk("byte_timeout", 0, 1);
    #1 rx_valid = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("start_err_clr", error, 0);
    chk("start_ready", rx_ready, 1);
    chk("start_hold", cpu_hold, 1);
  endtask

  task automatic load(input logic [15:0] n, input int gaps);
    logic [31:0] w;
    pulse_start();
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    if (n > 16'd256) begin
      repeat (3) @(negedge clk);
      chk("err_flag", error, 1);
      chk("err_ready", rx_ready, 0);
      chk("err_hold", cpu_hold, 1);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      exp_a.push_back(64'(i * 4));
      exp_d.push_back(w);
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], gaps);
    end
    exp_done++;
    for (int t = 0; t < 50 && done_seen != exp_done; t++) @(negedge clk);
    chk("done_count", done_seen, exp_done);
    repeat (2) @(negedge clk);
    chk("idle_hold", cpu_hold, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", error, 0);
    chk("pending_wr", exp_a.size(), 0);
  endtask

  task automatic fill(input int n, input bit inc);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(inc ? 32'(i) : $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rx_valid = 1;
    rx_data = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("idle_ready", rx_ready, 0);
    rx_valid = 0;

    words = '{32'h9100041F, 32'hD400001F};
    load(16'd2, 0);
    load(16'd257, 0);
    words = '{32'h9100041F, 32'hD400001F};
    load(16'd2, 1);

    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk) reset_n = 0;
    repeat (2) @(negedge clk);
    chk("abort_hold", cpu_hold, 0);
    chk("abort_ready", rx_ready, 0);
    reset_n = 1;
    fill(3, 0);
    load(16'd3, 2);
    chk("restart_addr0", last_addr, 64'h8);

    load(16'd0, 0);
    for (int s = 0; s < 4; s++) begin
      fill($urandom_range(1, 12), 0);
      load(16'(words.size()), 2);
    end

    fill(256, 1);
    load(16'd256, 0);
    chk("last_addr", last_addr, 64'h3FC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
